mem_resp_stage: RTL and testbench



---
 rtl/mem_resp_stage_if.sv | 53 +++++
 rtl/mem_resp_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_resp_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_stage_if.sv
// rtl/mem_resp_stage_if.sv - EX->MEM entry, data-sram response and MEM->WB handoff bundle
//
// Purpose: groups every handshake/bus signal of mem_resp_stage.
//   master : the surrounding pipeline (drives EX entry, sram response, flush, ws_allowin)
//   slave  : the MEM stage itself (drives allowin, WB payload, forwarding/hazard status)
interface mem_resp_stage_if;
  // EX -> MEM entry
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic        es_res_from_mem;
  logic [2:0]  es_load_op;
  logic [1:0]  es_addr_lo;
  logic [31:0] es_alu_result;
  logic [31:0] es_rt_value;
  logic        es_req;
  // data-sram response, in request order
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  // control from later stages
  logic        flush;
  logic        ws_allowin;
  // MEM -> WB payload
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic [3:0]  ms_rf_wen;
  logic [31:0] ms_final_result;
  // forwarding / hazard status
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_load_pending;
  logic        ms_discard_busy;

  modport master (
    output es_to_ms_valid, es_pc, es_dest, es_gr_we, es_res_from_mem, es_load_op,
           es_addr_lo, es_alu_result, es_rt_value, es_req,
           data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_rf_wen, ms_final_result,
           ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_load_pending, ms_discard_busy
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_dest, es_gr_we, es_res_from_mem, es_load_op,
           es_addr_lo, es_alu_result, es_rt_value, es_req,
           data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_rf_wen, ms_final_result,
           ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_load_pending, ms_discard_busy
  );
endinterface

// File: rtl/mem_resp_stage.sv
// rtl/mem_resp_stage.sv - MEM stage with load-response hold, flushed-response discard and load formatting
//
// Purpose: tracks one in-flight instruction (EMPTY/WAIT/READY), passes load data through
//   combinationally on data_ok or holds it while WB stalls, swallows responses of flushed
//   loads via a saturating discard counter, and formats LB/LBU/LH/LHU/LW(/LWL/LWR) results.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - mem_resp_stage_if.slave (EX entry, sram response, flush, WB handoff, forwarding)
// Parameters: MAX_DISCARD (1..7) maximum outstanding responses of flushed loads.
// Build option: define MS_UNALIGNED_EN to support LWL/LWR merge; otherwise ops 5/6 act as LW.
module mem_resp_stage #(
  parameter  int MAX_DISCARD = 3,
  localparam int CNT_W       = $clog2(MAX_DISCARD + 1)
) (
  input  logic              clk,
  input  logic              reset,
  mem_resp_stage_if.slave   bus
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DISCARD);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hold_q, hold_d;
  logic [31:0]       pc_q, pc_d;
  logic [4:0]        dest_q, dest_d;
  logic              gr_we_q, gr_we_d;
  logic              from_mem_q, from_mem_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        lo_q, lo_d;
  logic [31:0]       alu_q, alu_d;
`ifdef MS_UNALIGNED_EN
  logic [31:0]       rt_q, rt_d;
  logic [4:0]        lwl_sh, lwr_sh;
`endif

  logic        discard_hit, owned_ok, ms_valid, allowin, accept, kill_wait;
  logic [31:0] load_data, shifted, fmt_data, final_result;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  rf_wen;

  always_comb begin
    // A response is owned by the WAIT entry only once all flushed responses are drained.
    discard_hit = bus.data_sram_data_ok && (cnt_q != '0);
    owned_ok    = bus.data_sram_data_ok && (cnt_q == '0) && (state_q == S_WAIT);
    ms_valid    = !bus.flush && ((state_q == S_READY) || owned_ok);
    allowin     = ((state_q == S_EMPTY) || (ms_valid && bus.ws_allowin)) && (cnt_q != MAX_CNT);
    accept      = bus.es_to_ms_valid && allowin;
    // A flushed WAIT load still owes a response unless it arrives this very cycle.
    kill_wait   = bus.flush && (state_q == S_WAIT) && !owned_ok;

    state_d    = state_q;
    hold_d     = hold_q;
    pc_d       = pc_q;
    dest_d     = dest_q;
    gr_we_d    = gr_we_q;
    from_mem_d = from_mem_q;
    op_d       = op_q;
    lo_d       = lo_q;
    alu_d      = alu_q;
`ifdef MS_UNALIGNED_EN
    rt_d       = rt_q;
`endif

    case (state_q)
      S_WAIT: begin
        if (owned_ok) begin
          if (bus.ws_allowin) begin
            state_d = S_EMPTY;
          end else begin
            state_d = S_READY;
            hold_d  = bus.data_sram_rdata;
          end
        end
      end
      S_READY: if (bus.ws_allowin) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase

    if (bus.flush) state_d = S_EMPTY;

    if (accept) begin
      state_d    = bus.es_req ? S_WAIT : S_READY;
      pc_d       = bus.es_pc;
      dest_d     = bus.es_dest;
      gr_we_d    = bus.es_gr_we;
      from_mem_d = bus.es_res_from_mem;
      op_d       = bus.es_load_op;
      lo_d       = bus.es_addr_lo;
      alu_d      = bus.es_alu_result;
`ifdef MS_UNALIGNED_EN
      rt_d       = bus.es_rt_value;
`endif
    end

    // Simultaneous discard and kill cancel out; saturation is guaranteed by allowin.
    cnt_d = cnt_q;
    if (discard_hit && !kill_wait)      cnt_d = cnt_q - 1'b1;
    else if (!discard_hit && kill_wait) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    load_data = (state_q == S_WAIT) ? bus.data_sram_rdata : hold_q;
    shifted   = load_data >> {lo_q, 3'b000};
    byte_v    = shifted[7:0];
    half_v    = lo_q[1] ? load_data[31:16] : load_data[15:0];
    rf_wen    = {4{gr_we_q}};
`ifdef MS_UNALIGNED_EN
    lwl_sh    = {~lo_q, 3'b000};
    lwr_sh    = {lo_q, 3'b000};
`endif
    case (op_q)
      3'd1:    fmt_data = {{24{byte_v[7]}}, byte_v};
      3'd2:    fmt_data = {24'd0, byte_v};
      3'd3:    fmt_data = {{16{half_v[15]}}, half_v};
      3'd4:    fmt_data = {16'd0, half_v};
`ifdef MS_UNALIGNED_EN
      3'd5:    fmt_data = (load_data << lwl_sh) | (rt_q & ~(32'hffffffff << lwl_sh));
      3'd6:    fmt_data = (load_data >> lwr_sh) | (rt_q & ~(32'hffffffff >> lwr_sh));
`endif
      default: fmt_data = load_data;
    endcase
    if (from_mem_q) begin
`ifdef MS_UNALIGNED_EN
      if (op_q == 3'd5) rf_wen = 4'b1111 << (2'd3 - lo_q);
      if (op_q == 3'd6) rf_wen = 4'b1111 >> lo_q;
`else
      if (op_q == 3'd5 || op_q == 3'd6) rf_wen = 4'b1111;
`endif
    end
    final_result = from_mem_q ? fmt_data : alu_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      cnt_q      <= '0;
      hold_q     <= '0;
      pc_q       <= '0;
      dest_q     <= '0;
      gr_we_q    <= 1'b0;
      from_mem_q <= 1'b0;
      op_q       <= '0;
      lo_q       <= '0;
      alu_q      <= '0;
`ifdef MS_UNALIGNED_EN
      rt_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      pc_q       <= pc_d;
      dest_q     <= dest_d;
      gr_we_q    <= gr_we_d;
      from_mem_q <= from_mem_d;
      op_q       <= op_d;
      lo_q       <= lo_d;
      alu_q      <= alu_d;
`ifdef MS_UNALIGNED_EN
      rt_q       <= rt_d;
`endif
    end
  end

  assign bus.ms_allowin      = allowin;
  assign bus.ms_to_ws_valid  = ms_valid;
  assign bus.ms_pc           = pc_q;
  assign bus.ms_dest         = dest_q;
  assign bus.ms_rf_wen       = rf_wen;
  assign bus.ms_final_result = final_result;
  assign bus.ms_fwd_valid    = ms_valid && gr_we_q;
  assign bus.ms_fwd_dest     = dest_q;
  assign bus.ms_fwd_data     = final_result;
  assign bus.ms_load_pending = (state_q == S_WAIT) && !owned_ok;
  assign bus.ms_discard_busy = (cnt_q != '0);

endmodule

// File: tb/tb_mem_resp_stage.sv
// tb/tb_mem_resp_stage.sv - randomized and directed self-checking bench for mem_resp_stage
module tb_mem_resp_stage;
  localparam int MAXD = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_resp_stage_if bus ();
  mem_resp_stage #(.MAX_DISCARD(MAXD)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr_we;
    logic        from_mem;
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] rt;
  } entry_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the entry in MEM plus the list of outstanding sram requests in issue
  // order, each tagged with whether its owner has been flushed.
  entry_t      m_ent;
  bit          m_valid, m_have;
  logic [31:0] m_held;
  bit          outq[$];

  logic        obs_valid, obs_allow, obs_busy, obs_pend;
  logic [31:0] obs_final;
  logic [3:0]  obs_wen;

  function automatic logic [31:0] fmt(entry_t e, logic [31:0] d);
    int a = int'(e.lo);
    logic [7:0]  b = 8'(d >> (8 * a));
    logic [15:0] h = 16'(d >> (16 * (a / 2)));
    if (!e.from_mem) return e.alu;
    case (e.op)
      3'd1: return {{24{b[7]}}, b};
      3'd2: return {24'd0, b};
      3'd3: return {{16{h[15]}}, h};
      3'd4: return {16'd0, h};
`ifdef MS_UNALIGNED_EN
      3'd5: return (d << (8 * (3 - a))) | (e.rt & ~(32'hffffffff << (8 * (3 - a))));
      3'd6: return (d >> (8 * a)) | (e.rt & ~(32'hffffffff >> (8 * a)));
`endif
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] wen(entry_t e);
    logic [3:0] lwl_tab [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [3:0] lwr_tab [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
    if (e.from_mem && e.op == 3'd5) begin
`ifdef MS_UNALIGNED_EN
      return lwl_tab[e.lo];
`else
      return 4'b1111;
`endif
    end
    if (e.from_mem && e.op == 3'd6) begin
`ifdef MS_UNALIGNED_EN
      return lwr_tab[e.lo];
`else
      return 4'b1111;
`endif
    end
    return {4{e.gr_we}};
  endfunction

  function automatic entry_t mk(bit ld, int op, int lo, logic [31:0] rt);
    entry_t e;
    e.pc = $urandom; e.dest = 5'($urandom_range(1, 31)); e.gr_we = 1'b1;
    e.from_mem = ld; e.op = 3'(op); e.lo = 2'(lo); e.alu = $urandom; e.rt = rt;
    return e;
  endfunction

  // One clock: drive inputs, check combinational outputs against the model, advance the model.
  task automatic cyc(input bit v, input entry_t e, input bit req, input bit dok,
                     input logic [31:0] rd, input bit fl, input bit wa);
    int nkill = 0;
    bit live, xvalid, xallow, xfwd, acc;
    logic [31:0] xfinal;
    if (outq.size() == 0) dok = 1'b0;
    bus.es_to_ms_valid = v;       bus.es_pc = e.pc;           bus.es_dest = e.dest;
    bus.es_gr_we = e.gr_we;       bus.es_res_from_mem = e.from_mem;
    bus.es_load_op = e.op;        bus.es_addr_lo = e.lo;      bus.es_alu_result = e.alu;
    bus.es_rt_value = e.rt;       bus.es_req = req;
    bus.data_sram_data_ok = dok;  bus.data_sram_rdata = rd;
    bus.flush = fl;               bus.ws_allowin = wa;
    #2;
    foreach (outq[i]) if (outq[i]) nkill++;
    live   = dok && !outq[0];
    xvalid = !fl && m_valid && (m_have || live);
    xallow = (!m_valid || (xvalid && wa)) && (nkill != MAXD);
    xfwd   = xvalid && m_ent.gr_we;
    xfinal = fmt(m_ent, m_have ? m_held : rd);
    obs_valid = bus.ms_to_ws_valid; obs_allow = bus.ms_allowin; obs_busy = bus.ms_discard_busy;
    obs_pend  = bus.ms_load_pending; obs_final = bus.ms_final_result; obs_wen = bus.ms_rf_wen;
    chk("to_ws_valid", 32'(bus.ms_to_ws_valid), 32'(xvalid));
    chk("allowin", 32'(bus.ms_allowin), 32'(xallow));
    chk("discard_busy", 32'(bus.ms_discard_busy), 32'(nkill != 0));
    chk("load_pending", 32'(bus.ms_load_pending), 32'(m_valid && !m_have && !live));
    chk("fwd_valid", 32'(bus.ms_fwd_valid), 32'(xfwd));
    if (xvalid) begin
      chk("final_result", bus.ms_final_result, xfinal);
      chk("rf_wen", 32'(bus.ms_rf_wen), 32'(wen(m_ent)));
      chk("pc", bus.ms_pc, m_ent.pc);
      chk("dest", 32'(bus.ms_dest), 32'(m_ent.dest));
    end
    if (xfwd) begin
      chk("fwd_data", bus.ms_fwd_data, xfinal);
      chk("fwd_dest", 32'(bus.ms_fwd_dest), 32'(m_ent.dest));
    end
    @(posedge clk);
    #1;
    acc = v && xallow;
    if (fl && m_valid && !m_have && !live) outq[outq.size() - 1] = 1'b1;
    if (dok) void'(outq.pop_front());
    if (xvalid && wa) m_valid = 1'b0;
    else if (live && !fl) begin m_have = 1'b1; m_held = rd; end
    if (fl) m_valid = 1'b0;
    if (acc) begin
      m_ent = e; m_valid = 1'b1; m_have = !req;
      if (req) outq.push_back(1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.data_sram_data_ok = 1'b1;
    bus.flush = 1'b1;
    bus.es_to_ms_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_valid = 1'b0; m_have = 1'b0; m_held = '0;
    outq.delete();
  endtask

  entry_t idle_e;
  entry_t e;

  initial begin
    idle_e = mk(0, 0, 0, 32'h0);
    reset = 1'b1;
    bus.es_to_ms_valid = 1'b0; bus.data_sram_data_ok = 1'b0; bus.flush = 1'b0;
    bus.ws_allowin = 1'b1; bus.es_req = 1'b0; bus.data_sram_rdata = '0;
    bus.es_pc = '0; bus.es_dest = '0; bus.es_gr_we = 1'b0; bus.es_res_from_mem = 1'b0;
    bus.es_load_op = '0; bus.es_addr_lo = '0; bus.es_alu_result = '0; bus.es_rt_value = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // reset state
    cyc(0, idle_e, 0, 0, 0, 0, 1);
    chk("rst_allowin", 32'(obs_allow), 32'd1);
    chk("rst_valid", 32'(obs_valid), 32'd0);
    chk("rst_busy", 32'(obs_busy), 32'd0);

    // LB a=3, data_ok two cycles after accept
    cyc(1, mk(1, 1, 3, 0), 1, 0, 0, 0, 1);
    cyc(0, idle_e, 0, 0, 0, 0, 1);
    chk("lb_wait_valid", 32'(obs_valid), 32'd0);
    cyc(0, idle_e, 0, 1, 32'h80112233, 0, 1);
    chk("lb_result", obs_final, 32'hffffff80);
    chk("lb_valid", 32'(obs_valid), 32'd1);
    cyc(0, idle_e, 0, 0, 0, 0, 1);

    // LW held across a 3-cycle WB stall
    cyc(1, mk(1, 0, 0, 0), 1, 0, 0, 0, 1);
    cyc(0, idle_e, 0, 1, 32'hdeadbeef, 0, 0);
    cyc(1, mk(0, 0, 0, 0), 0, 0, 0, 0, 0);
    cyc(1, mk(0, 0, 0, 0), 0, 0, 0, 0, 0);
    chk("hold_allowin", 32'(obs_allow), 32'd0);
    cyc(0, idle_e, 0, 0, 32'h0, 0, 1);
    chk("hold_data", obs_final, 32'hdeadbeef);

    // flush in WAIT, next LW: first response discarded, second delivered
    cyc(1, mk(1, 0, 0, 0), 1, 0, 0, 0, 1);
    cyc(0, idle_e, 0, 0, 0, 1, 1);
    cyc(1, mk(1, 0, 0, 0), 1, 0, 0, 0, 1);
    chk("disc_busy", 32'(obs_busy), 32'd1);
    cyc(0, idle_e, 0, 1, 32'h1, 0, 1);
    chk("disc_drop", 32'(obs_valid), 32'd0);
    cyc(0, idle_e, 0, 1, 32'h2, 0, 1);
    chk("disc_deliver", obs_final, 32'h2);
    chk("disc_idle", 32'(obs_busy), 32'd0);

    // three flushed loads saturate the discard counter
    repeat (3) begin
      cyc(1, mk(1, 0, 0, 0), 1, 0, 0, 0, 1);
      cyc(0, idle_e, 0, 0, 0, 1, 1);
    end
    cyc(1, mk(0, 0, 0, 0), 0, 0, 0, 0, 1);
    chk("sat_allowin", 32'(obs_allow), 32'd0);
    cyc(1, mk(0, 0, 0, 0), 0, 1, 32'h5, 0, 1);
    chk("sat_still", 32'(obs_allow), 32'd0);
    cyc(0, idle_e, 0, 0, 0, 0, 1);
    chk("sat_release", 32'(obs_allow), 32'd1);
    repeat (2) cyc(0, idle_e, 0, 1, 32'h6, 0, 1);

    // LWL / LWR merge
    cyc(1, mk(1, 5, 1, 32'haabbccdd), 1, 0, 0, 0, 1);
    cyc(0, idle_e, 0, 1, 32'h11223344, 0, 1);
`ifdef MS_UNALIGNED_EN
    chk("lwl_result", obs_final, 32'h3344ccdd);
    chk("lwl_wen", 32'(obs_wen), 32'b1100);
`else
    chk("lwl_result", obs_final, 32'h11223344);
    chk("lwl_wen", 32'(obs_wen), 32'b1111);
`endif
    cyc(1, mk(1, 6, 2, 32'haabbccdd), 1, 0, 0, 0, 1);
    cyc(0, idle_e, 0, 1, 32'h11223344, 0, 1);
`ifdef MS_UNALIGNED_EN
    chk("lwr_result", obs_final, 32'haabb1122);
    chk("lwr_wen", 32'(obs_wen), 32'b0011);
`else
    chk("lwr_result", obs_final, 32'h11223344);
    chk("lwr_wen", 32'(obs_wen), 32'b1111);
`endif

    // reset while in WAIT with two discards pending
    repeat (2) begin
      cyc(1, mk(1, 0, 0, 0), 1, 0, 0, 0, 1);
      cyc(0, idle_e, 0, 0, 0, 1, 1);
    end
    cyc(1, mk(1, 0, 0, 0), 1, 0, 0, 0, 1);
    do_reset();
    cyc(0, idle_e, 0, 0, 0, 0, 1);
    chk("rst2_valid", 32'(obs_valid), 32'd0);
    chk("rst2_busy", 32'(obs_busy), 32'd0);
    chk("rst2_pend", 32'(obs_pend), 32'd0);
    chk("rst2_allow", 32'(obs_allow), 32'd1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit ld = ($urandom_range(0, 9) < 6);
      e = mk(ld, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), $urandom);
      if (!ld) e.gr_we = 1'($urandom);
      cyc(($urandom_range(0, 9) < 7), e, ld, 1'($urandom), $urandom,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
